// File: rtl/score_keeper.sv
// ----------------------------------------------------------------------------
// score_keeper
//
// Snake-game score unit. Counts food events directly in packed BCD, keeps a
// session high score and drives a DIGITS-wide multiplexed 7-segment display
// with leading-zero blanking. In game-over the display alternates between the
// score and the high score.
//
// Parameters
//   DIGITS    BCD digits of score, high score and display (1..8)
//   POINTS    BCD value added per food event (1..9)
//   GAME_RUN  game_state encoding meaning "running"
//   SCAN_BITS refresh counter width; display digit advances on each wrap
//   ALT_BITS  alternation counter width; score/high view toggles on each wrap
//
// Ports
//   clk         in   1          system clock, rising edge
//   rst         in   1          asynchronous active-low reset
//   game_state  in   2          game FSM state
//   get_food    in   1          asynchronous food strobe, event on falling edge
//   clr_high    in   1          synchronous clear of the high score
//   AN          out  DIGITS     digit enables, active-low, AN[0] = LS digit
//   SEG         out  8          segments active-low, SEG[6:0] = g..a, SEG[7] = dp
//   score_bcd   out  4*DIGITS   current score, packed BCD
//   high_bcd    out  4*DIGITS   session high score, packed BCD
//   new_high    out  1          high score updated since the last clear
//   overflow    out  1          sticky, score saturated at all nines
// ----------------------------------------------------------------------------
module score_keeper #(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned POINTS    = 1,
    parameter logic [1:0]  GAME_RUN  = 2'b00,
    parameter int unsigned SCAN_BITS = 17,
    parameter int unsigned ALT_BITS  = 26
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            game_state,
    input  logic                  get_food,
    input  logic                  clr_high,
    output logic [DIGITS-1:0]     AN,
    output logic [7:0]            SEG,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic [4*DIGITS-1:0]   high_bcd,
    output logic                  new_high,
    output logic                  overflow
);

    localparam int unsigned     W         = 4 * DIGITS;
    localparam int unsigned     IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [W-1:0]    ALL_NINES = {DIGITS{4'h9}};
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    // ------------------------------------------------------------------------
    // Food strobe synchroniser and falling-edge detector
    // ------------------------------------------------------------------------
    logic food_s1_q, food_s2_q, food_hist_q;
    logic food_fall;
    logic food_ev_q;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values of the others; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            food_s1_q   <= 1'b1;
            food_s2_q   <= 1'b1;
            food_hist_q <= 1'b1;
            food_ev_q   <= 1'b0;
        end else begin
            food_s1_q   <= get_food;
            food_s2_q   <= food_s1_q;
            food_hist_q <= food_s2_q;
            food_ev_q   <= food_fall;
        end
    end

    // Synchronised level is low and was high one cycle earlier.
    assign food_fall = !food_s2_q && food_hist_q;

    // ------------------------------------------------------------------------
    // Run detection
    // ------------------------------------------------------------------------
    logic run;
    logic run_d_q;
    logic game_start;

    assign run        = (game_state == GAME_RUN);
    assign game_start = run && !run_d_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_d_q <= 1'b0;
        end else begin
            run_d_q <= run;
        end
    end

    // ------------------------------------------------------------------------
    // BCD adder: score + POINTS, rippling a decimal carry digit by digit
    // ------------------------------------------------------------------------
    logic [W-1:0] score_q, score_d;
    logic [W-1:0] sum_bcd;
    logic         sum_carry;

    // NOTE: every variable written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        logic [4:0] dsum;
        logic       carry;
        sum_bcd = '0;
        dsum    = '0;
        carry   = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            dsum = {1'b0, score_q[4*i +: 4]} + {4'd0, carry}
                 + ((i == 0) ? 5'(POINTS) : 5'd0);
            if (dsum > 5'd9) begin
                sum_bcd[4*i +: 4] = 4'(dsum - 5'd10);
                carry             = 1'b1;
            end else begin
                sum_bcd[4*i +: 4] = dsum[3:0];
                carry             = 1'b0;
            end
        end
        sum_carry = carry;
    end

    // ------------------------------------------------------------------------
    // Score register: game start clears, counted events add, otherwise hold
    // ------------------------------------------------------------------------
    logic overflow_q, overflow_d;
    logic scored_q, scored_d;

    always_comb begin
        score_d    = score_q;
        overflow_d = overflow_q;
        scored_d   = 1'b0;
        if (game_start) begin
            // An event coinciding with game start is intentionally dropped.
            score_d    = '0;
            overflow_d = 1'b0;
        end else if (food_ev_q && run) begin
            scored_d = 1'b1;
            if (sum_carry) begin
                score_d    = ALL_NINES;
                overflow_d = 1'b1;
            end else begin
                score_d = sum_bcd;
            end
        end
    end

    // NOTE: the high score is deliberately reset along with everything else;
    // it is a session value and is not retained across reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            score_q    <= '0;
            overflow_q <= 1'b0;
            scored_q   <= 1'b0;
        end else begin
            score_q    <= score_d;
            overflow_q <= overflow_d;
            scored_q   <= scored_d;
        end
    end

    // ------------------------------------------------------------------------
    // High score: compared one cycle after each counted event. Packed BCD
    // orders the same way as the decimal value, so a plain compare works.
    // ------------------------------------------------------------------------
    logic [W-1:0] high_q, high_d;
    logic         new_high_q, new_high_d;

    always_comb begin
        high_d     = high_q;
        new_high_d = new_high_q;
        if (clr_high) begin
            high_d     = '0;
            new_high_d = 1'b0;
        end else if (scored_q && (score_q > high_q)) begin
            high_d     = score_q;
            new_high_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            high_q     <= '0;
            new_high_q <= 1'b0;
        end else begin
            high_q     <= high_d;
            new_high_q <= new_high_d;
        end
    end

    // ------------------------------------------------------------------------
    // Digit scan: refresh counter, digit index advances on counter wrap
    // ------------------------------------------------------------------------
    logic [SCAN_BITS-1:0] scan_cnt_q;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 scan_wrap;

    assign scan_wrap = &scan_cnt_q;

    always_comb begin
        idx_d = idx_q;
        if (scan_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt_q <= '0;
            idx_q      <= '0;
        end else begin
            scan_cnt_q <= scan_cnt_q + SCAN_BITS'(1);
            idx_q      <= idx_d;
        end
    end

    // ------------------------------------------------------------------------
    // Score/high alternation, held at "score" for the whole running phase so
    // every game-over display starts on the score.
    // ------------------------------------------------------------------------
    logic [ALT_BITS-1:0] alt_cnt_q;
    logic                show_high_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alt_cnt_q   <= '0;
            show_high_q <= 1'b0;
        end else if (run) begin
            alt_cnt_q   <= '0;
            show_high_q <= 1'b0;
        end else begin
            alt_cnt_q <= alt_cnt_q + ALT_BITS'(1);
            if (&alt_cnt_q) begin
                show_high_q <= !show_high_q;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Display source, blanking and segment decode
    // ------------------------------------------------------------------------
    function automatic logic [7:0] seg_decode(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = 8'hFF;
        endcase
        return seg;
    endfunction

    logic [W-1:0]      src_bcd;
    logic [DIGITS-1:0] shown;
    logic [3:0]        sel_nib;
    logic              sel_shown;
    logic [DIGITS-1:0] an_q, an_d;
    logic [7:0]        seg_q, seg_d;

    assign src_bcd = (run || !show_high_q) ? score_q : high_q;

    // A digit is lit if it or any higher digit is nonzero; digit 0 always is.
    always_comb begin
        logic seen;
        seen  = 1'b0;
        shown = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            seen     = seen | (src_bcd[4*i +: 4] != 4'd0);
            shown[i] = seen || (i == 0);
        end
    end

    assign sel_nib   = src_bcd[4*idx_q +: 4];
    assign sel_shown = shown[idx_q];

    always_comb begin
        an_d  = ~(DIGITS'(1) << idx_q);
        seg_d = sel_shown ? seg_decode(sel_nib) : 8'hFF;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_q  <= '1;
            seg_q <= 8'hFF;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign AN        = an_q;
    assign SEG       = seg_q;
    assign score_bcd = score_q;
    assign high_bcd  = high_q;
    assign new_high  = new_high_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_score_keeper.sv
// ----------------------------------------------------------------------------
// tb_score_keeper
//
// Two score_keeper instances: A (4 digits, 1 point per food) and B (2 digits,
// 5 points per food), both with short scan/alternation counters. A decimal
// model of each instance is advanced on every rising edge; all outputs are
// compared against it on every falling edge, and directed scenarios add
// hand-computed literal expectations.
// ----------------------------------------------------------------------------
module tb_score_keeper;

    localparam int NI  = 2;
    localparam int D_A = 4, P_A = 1, S_A = 2, A_A = 5;
    localparam int D_B = 2, P_B = 5, S_B = 2, A_B = 4;
    localparam logic [1:0] RUN_ST  = 2'b00;
    localparam logic [1:0] OVER_ST = 2'b01;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       gf  [NI];
    logic [1:0] gs  [NI];
    logic       clr [NI];

    always #5 clk = ~clk;

    logic [3:0]  a_an;
    logic [7:0]  a_seg;
    logic [15:0] a_score, a_high;
    logic        a_nh, a_ov;
    logic [1:0]  b_an;
    logic [7:0]  b_seg;
    logic [7:0]  b_score, b_high;
    logic        b_nh, b_ov;

    score_keeper #(.DIGITS(D_A), .POINTS(P_A), .GAME_RUN(RUN_ST),
                   .SCAN_BITS(S_A), .ALT_BITS(A_A)) dut_a (
        .clk(clk), .rst(rst), .game_state(gs[0]), .get_food(gf[0]),
        .clr_high(clr[0]), .AN(a_an), .SEG(a_seg), .score_bcd(a_score),
        .high_bcd(a_high), .new_high(a_nh), .overflow(a_ov));

    score_keeper #(.DIGITS(D_B), .POINTS(P_B), .GAME_RUN(RUN_ST),
                   .SCAN_BITS(S_B), .ALT_BITS(A_B)) dut_b (
        .clk(clk), .rst(rst), .game_state(gs[1]), .get_food(gf[1]),
        .clr_high(clr[1]), .AN(b_an), .SEG(b_seg), .score_bcd(b_score),
        .high_bcd(b_high), .new_high(b_nh), .overflow(b_ov));

    logic [31:0] act_score [NI];
    logic [31:0] act_high  [NI];
    logic [31:0] act_an    [NI];
    logic [31:0] act_seg   [NI];
    logic [31:0] act_nh    [NI];
    logic [31:0] act_ov    [NI];

    assign act_score[0] = 32'(a_score);
    assign act_score[1] = 32'(b_score);
    assign act_high[0]  = 32'(a_high);
    assign act_high[1]  = 32'(b_high);
    assign act_an[0]    = 32'(a_an);
    assign act_an[1]    = 32'(b_an);
    assign act_seg[0]   = 32'(a_seg);
    assign act_seg[1]   = 32'(b_seg);
    assign act_nh[0]    = 32'(a_nh);
    assign act_nh[1]    = 32'(b_nh);
    assign act_ov[0]    = 32'(a_ov);
    assign act_ov[1]    = 32'(b_ov);

    int checks = 0;
    int errors = 0;

    function automatic int dig_of(int i);  return (i == 0) ? D_A : D_B; endfunction
    function automatic int pts_of(int i);  return (i == 0) ? P_A : P_B; endfunction
    function automatic int scan_of(int i); return (i == 0) ? S_A : S_B; endfunction
    function automatic int alt_of(int i);  return (i == 0) ? A_A : A_B; endfunction

    logic [7:0] seg_lut [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    function automatic int pow10(int e);
        int p = 1;
        for (int k = 0; k < e; k++) p = p * 10;
        return p;
    endfunction

    function automatic logic [31:0] to_bcd(int v);
        logic [31:0] r = '0;
        int x = v;
        for (int k = 0; k < 8; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Digit idx of decimal value v, blank above the leading nonzero digit.
    function automatic logic [31:0] seg_of(int v, int idx);
        if (idx > 0 && v < pow10(idx)) return 32'hFF;
        return 32'(seg_lut[(v / pow10(idx)) % 10]);
    endfunction

    // ------------------------------------------------------------------------
    // Decimal model, one step per rising edge
    // ------------------------------------------------------------------------
    int          m_score  [NI];
    int          m_high   [NI];
    bit          m_nh     [NI];
    bit          m_ov     [NI];
    bit          m_scored [NI];
    bit          m_prev   [NI];
    bit          m_gf     [NI][5];   // get_food samples, [0] = this edge
    int          m_n      [NI];      // edges since reset
    int          m_j      [NI];      // consecutive game-over edges
    logic [31:0] exp_an   [NI];
    logic [31:0] exp_seg  [NI];

    always @(posedge clk or negedge rst) begin : model
        int  idx, src, lim;
        bit  run, ev;
        for (int i = 0; i < NI; i++) begin
            if (!rst) begin
                m_score[i]  = 0;
                m_high[i]   = 0;
                m_nh[i]     = 1'b0;
                m_ov[i]     = 1'b0;
                m_scored[i] = 1'b0;
                m_prev[i]   = 1'b0;
                for (int h = 0; h < 5; h++) m_gf[i][h] = 1'b1;
                m_n[i]      = 0;
                m_j[i]      = 0;
                exp_an[i]   = 32'((1 << dig_of(i)) - 1);
                exp_seg[i]  = 32'hFF;
            end else begin
                run = (gs[i] == RUN_ST);
                // display registers take the pre-edge index, view and values
                idx = (m_n[i] / (1 << scan_of(i))) % dig_of(i);
                src = (!run && ((m_j[i] / (1 << alt_of(i))) % 2 == 1)) ? m_high[i] : m_score[i];
                exp_an[i]  = 32'(((1 << dig_of(i)) - 1) & ~(1 << idx));
                exp_seg[i] = seg_of(src, idx);
                // high score follows the score one cycle after a counted event
                if (clr[i]) begin
                    m_high[i] = 0;
                    m_nh[i]   = 1'b0;
                end else if (m_scored[i] && m_score[i] > m_high[i]) begin
                    m_high[i] = m_score[i];
                    m_nh[i]   = 1'b1;
                end
                // a falling edge first sampled at edge k is scored at edge k+3
                for (int h = 4; h > 0; h--) m_gf[i][h] = m_gf[i][h-1];
                m_gf[i][0] = gf[i];
                ev = !m_gf[i][3] && m_gf[i][4];
                lim = pow10(dig_of(i)) - 1;
                m_scored[i] = 1'b0;
                if (run && !m_prev[i]) begin
                    m_score[i] = 0;
                    m_ov[i]    = 1'b0;
                end else if (ev && run) begin
                    m_scored[i] = 1'b1;
                    m_score[i]  = m_score[i] + pts_of(i);
                    if (m_score[i] > lim) begin
                        m_score[i] = lim;
                        m_ov[i]    = 1'b1;
                    end
                end
                m_prev[i] = run;
                m_n[i]    = m_n[i] + 1;
                m_j[i]    = run ? 0 : m_j[i] + 1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Checking and stimulus helpers
    // ------------------------------------------------------------------------
    task automatic check(input string name, input int inst,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %h expected %h at %0t", name, inst, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and compare every output to the model.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check("score", i, act_score[i], to_bcd(m_score[i]));
            check("high",  i, act_high[i],  to_bcd(m_high[i]));
            check("new_high", i, act_nh[i], 32'(m_nh[i]));
            check("overflow", i, act_ov[i], 32'(m_ov[i]));
            check("an",    i, act_an[i],  exp_an[i]);
            check("seg",   i, act_seg[i], exp_seg[i]);
        end
    endtask

    // get_food low for lo edges, then high; optional clr_high in the cycle
    // right after the score update.
    task automatic pulse(input int inst, input int lo, input bit clr_on_upd);
        tick();
        gf[inst] = 1'b0;
        for (int c = 1; c <= lo + 6; c++) begin
            tick();
            if (c == lo) gf[inst] = 1'b1;
            clr[inst] = clr_on_upd && (c == 4);
        end
    endtask

    task automatic pulses(input int inst, input int n);
        for (int k = 0; k < n; k++) pulse(inst, 4, 1'b0);
    endtask

    task automatic set_state(input int inst, input logic [1:0] st);
        tick();
        gs[inst] = st;
    endtask

    // Re-enter run on the very edge where a food event would be scored.
    task automatic restart_coincident(input int inst);
        tick();
        gf[inst] = 1'b0;
        repeat (3) tick();
        gs[inst] = RUN_ST;
        tick();
        gf[inst] = 1'b1;
        repeat (6) tick();
    endtask

    // Wait up to 16 cycles for instance A to enable the given digit.
    task automatic find_an_a(input logic [31:0] an_val, output bit found);
        found = 1'b0;
        for (int c = 0; c < 16 && !found; c++) begin
            tick();
            if (act_an[0] == an_val) found = 1'b1;
        end
    endtask

    // ------------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------------
    initial begin
        bit found;
        gf  = '{1'b1, 1'b1};
        gs  = '{OVER_ST, OVER_ST};
        clr = '{1'b0, 1'b0};
        rst = 1'b0;

        repeat (3) tick();
        check("rst_score_lit", 0, act_score[0], 32'h0);
        check("rst_an_lit",    0, act_an[0],    32'hF);
        check("rst_seg_lit",   0, act_seg[0],   32'hFF);
        rst = 1'b1;
        repeat (2) tick();

        // Three events from a fresh game
        set_state(0, RUN_ST);
        pulses(0, 3);
        repeat (2) tick();
        check("t1_score_lit", 0, act_score[0], 32'h0003);
        check("t1_high_lit",  0, act_high[0],  32'h0003);
        check("t1_nh_lit",    0, act_nh[0],    32'h1);

        // Decimal carry, one long low pulse counted once
        pulses(0, 5);
        check("t2_score8_lit", 0, act_score[0], 32'h0008);
        for (int k = 0; k < 9; k++) pulse(0, (k == 4) ? 12 : 4, 1'b0);
        check("t2_score17_lit", 0, act_score[0], 32'h0017);

        // Events after game over are ignored; restart drops a coincident event
        set_state(0, OVER_ST);
        pulses(0, 1);
        check("t4_hold_lit", 0, act_score[0], 32'h0017);
        restart_coincident(0);
        check("t4_restart_lit", 0, act_score[0], 32'h0000);
        check("t4_high_kept_lit", 0, act_high[0], 32'h0017);
        check("t4_ovf_lit", 0, act_ov[0], 32'h0);

        // clr_high wins over the same-cycle high update
        pulses(0, 42);
        check("t5_high42_lit", 0, act_high[0], 32'h0042);
        pulses(0, 7);
        pulse(0, 4, 1'b1);
        check("t5_score50_lit", 0, act_score[0], 32'h0050);
        check("t5_high_clr_lit", 0, act_high[0], 32'h0000);
        check("t5_nh_clr_lit", 0, act_nh[0], 32'h0);
        pulses(0, 1);
        check("t5_high51_lit", 0, act_high[0], 32'h0051);
        check("t5_nh51_lit", 0, act_nh[0], 32'h1);

        // Scan and blanking with score 7, then the high-score view in game over
        set_state(0, OVER_ST);
        repeat (3) tick();
        gs[0] = RUN_ST;
        pulses(0, 7);
        find_an_a(32'hE, found);
        check("t6_an0_seen", 0, 32'(found), 32'h1);
        if (found) check("t6_seg_d0_lit", 0, act_seg[0], 32'hF8);
        find_an_a(32'h7, found);
        check("t6_an3_seen", 0, 32'(found), 32'h1);
        if (found) check("t6_seg_d3_lit", 0, act_seg[0], 32'hFF);
        set_state(0, OVER_ST);
        repeat (40) tick();
        find_an_a(32'hD, found);
        check("t6_an1_seen", 0, 32'(found), 32'h1);
        if (found) check("t6_high_d1_lit", 0, act_seg[0], 32'h92);

        // Two-digit instance: saturation at 99
        set_state(1, RUN_ST);
        pulses(1, 19);
        check("t3_score95_lit", 1, act_score[1], 32'h95);
        check("t3_ovf0_lit", 1, act_ov[1], 32'h0);
        pulses(1, 1);
        check("t3_sat_lit", 1, act_score[1], 32'h99);
        check("t3_ovf1_lit", 1, act_ov[1], 32'h1);
        pulses(1, 1);
        check("t3_sat2_lit", 1, act_score[1], 32'h99);
        check("t3_ovf2_lit", 1, act_ov[1], 32'h1);

        // Reset mid-operation takes effect without a clock edge
        tick();
        #2 rst = 1'b0;
        #1;
        check("arst_score_lit", 0, act_score[0], 32'h0);
        check("arst_high_lit",  0, act_high[0],  32'h0);
        check("arst_an_lit",    0, act_an[0],    32'hF);
        check("arst_ovf_lit",   1, act_ov[1],    32'h0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
